twos_comp_serial_conv: RTL and testbench

Parametrised, bit-serial two's-complement conversion engine with valid/ready handshakes on both sides. It accepts one WIDTH-bit word per transaction and processes it LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule. It supports pass-through, negate, absolute-value and sign-magnitude-to-two's-complement modes, and flags overflow. It sits between a producer and consumer in the arithmetic datapath where area matters more than throughput.

---
 rtl/twos_comp_serial_conv_pkg.sv | 25 ++
 rtl/twos_comp_serial_conv_neg_cell.sv | 26 ++
 rtl/twos_comp_serial_conv.sv | 119 +++++++++++
 tb/tb_twos_comp_serial_conv.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/twos_comp_serial_conv_pkg.sv
// Shared types and the overflow predicate for the bit-serial two's-complement converter.
package twos_comp_pkg;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      NEG   = 2'd1,
      ABS   = 2'd2,
      SM2TC = 2'd3
   } tc_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } tc_state_e;

   // Only the most negative value cannot be negated in range.
   function automatic logic tc_ovf(input tc_mode_e mode, input logic [63:0] data,
                                   input int unsigned width);
      logic [63:0] w_min;
      w_min = 64'd1 << (width - 1);
      return ((mode == NEG) || (mode == ABS)) && (data == w_min);
   endfunction

endpackage

// File: rtl/twos_comp_serial_conv_neg_cell.sv
// One-bit serial negation cell: copies bits until the first one, then inverts the rest.
module tc_serial_neg_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic i_bit,
   input  logic i_neg,
   input  logic i_clear,
   input  logic i_en,
   output logic o_bit
);

   logic r_seen_one;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seen_one <= 1'b0;
      end else if (i_clear) begin
         r_seen_one <= 1'b0;
      end else if (i_en) begin
         r_seen_one <= r_seen_one | i_bit;
      end
   end

   assign o_bit = i_bit ^ (i_neg & r_seen_one);

endmodule

// File: rtl/twos_comp_serial_conv.sv
// Bit-serial two's-complement converter (PASS/NEG/ABS/SM2TC), LSB first, one bit per clock.
// Define TWOS_COMP_SAT_EN to saturate overflowing results instead of wrapping.
//
// state | meaning
// IDLE  | ready for a word once out of reset
// SHIFT | processing one bit per clock, WIDTH clocks
// DONE  | result presented, waiting for out_ready
module twos_comp_serial_conv #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf
);
   import twos_comp_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   tc_state_e        r_state;
   tc_state_e        w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_neg;
   logic             r_ovf;
   logic             r_started;
   logic             w_accept;
   logic             w_last;
   logic             w_res_bit;
   tc_mode_e         w_mode;

   assign w_mode   = tc_mode_e'(in_mode);
   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = r_started;
            if (w_accept) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // r_started keeps in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_ovf     <= 1'b0;
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
         if (w_accept) begin
            r_cnt <= '0;
            r_ovf <= tc_ovf(w_mode, 64'(in_data), WIDTH);
            case (w_mode)
               PASS:    r_neg <= 1'b0;
               NEG:     r_neg <= 1'b1;
               default: r_neg <= in_data[WIDTH-1];
            endcase
            // Sign-magnitude input: drop the sign bit, negate only the magnitude.
            if (w_mode == SM2TC) begin
               r_shift <= {1'b0, in_data[WIDTH-2:0]};
            end else begin
               r_shift <= in_data;
            end
         end else if (r_state == SHIFT) begin
            r_shift <= {w_res_bit, r_shift[WIDTH-1:1]};
            r_cnt   <= r_cnt + CW'(1);
         end
      end
   end

   tc_serial_neg_cell u_neg_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_bit   (r_shift[0]),
      .i_neg   (r_neg),
      .i_clear (w_accept),
      .i_en    (r_state == SHIFT),
      .o_bit   (w_res_bit)
   );

`ifdef TWOS_COMP_SAT_EN
   assign out_data = r_ovf ? {1'b0, {(WIDTH-1){1'b1}}} : r_shift;
`else
   assign out_data = r_shift;
`endif

   assign out_ovf = r_ovf & (r_state == DONE);

endmodule

// File: tb/tb_twos_comp_serial_conv.sv
// Self-checking bench: directed vector table, random words vs arithmetic model, multi-cycle corner cases.
module tb_twos_comp_serial_conv;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v8, i8_ready, o8_valid, oready8, o8_ovf;
   logic [7:0] d8, o8_data;
   logic [1:0] m8;
   logic       v4, i4_ready, o4_valid, oready4, o4_ovf;
   logic [3:0] d4, o4_data;
   logic [1:0] m4;

   int checks   = 0;
   int failures = 0;

   twos_comp_serial_conv #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(i8_ready), .in_data(d8),
      .in_mode(m8), .out_valid(o8_valid), .out_ready(oready8), .out_data(o8_data),
      .out_ovf(o8_ovf));

   twos_comp_serial_conv #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(i4_ready), .in_data(d4),
      .in_mode(m4), .out_valid(o4_valid), .out_ready(oready4), .out_data(o4_data),
      .out_ovf(o4_ovf));

`ifdef TWOS_COMP_SAT_EN
   localparam logic [7:0] OVF_RES = 8'h7F;
`else
   localparam logic [7:0] OVF_RES = 8'h80;
`endif

   typedef struct {
      logic [1:0] mode;
      logic [7:0] din;
      logic [7:0] exp_data;
      logic       exp_ovf;
   } vec_t;

   vec_t tab[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference: plain modular arithmetic on the integer value of the word.
   function automatic void model8(input logic [1:0] mode, input logic [7:0] d,
                                  output logic [7:0] r, output logic o);
      int v;
      int mag;
      v = int'(d);
      mag = v % 128;
      o = 1'b0;
      case (mode)
         2'd0:    r = d;
         2'd1:    r = 8'((256 - v) % 256);
         2'd2:    r = (v >= 128) ? 8'((256 - v) % 256) : d;
         default: r = (v >= 128) ? 8'((256 - mag) % 256) : 8'(mag);
      endcase
      if ((mode == 2'd1 || mode == 2'd2) && v == 128) begin
         o = 1'b1;
`ifdef TWOS_COMP_SAT_EN
         r = 8'h7F;
`endif
      end
   endfunction

   task automatic run8(input logic [1:0] mode, input logic [7:0] din, input logic [7:0] ed,
                       input logic eo, input int hold, input string nm);
      int k;
      int lat;
      int bad;
      k = 0;
      while (!i8_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk({nm, "_ready"}, i8_ready, 1);
      m8 = mode; d8 = din; v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0; d8 = 8'($urandom); m8 = 2'($urandom);
      lat = 0; bad = 0;
      while (!o8_valid && lat < 50) begin
         if (i8_ready) bad++;
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, lat, 8);
      chk({nm, "_data"}, o8_data, ed);
      chk({nm, "_ovf"}, o8_ovf, eo);
      chk({nm, "_busy_ready"}, bad, 0);
      for (int h = 0; h < hold; h++) begin
         v8 = ~v8; d8 = 8'($urandom);
         @(posedge clk); #1;
         if (!(o8_valid && o8_data == ed && o8_ovf == eo && !i8_ready)) bad++;
      end
      if (hold > 0) chk({nm, "_hold"}, bad, 0);
      v8 = 1'b0; oready8 = 1'b1;
      @(posedge clk); #1;
      oready8 = 1'b0;
      chk({nm, "_drop"}, {o8_valid, i8_ready}, 2'b01);
   endtask

   logic [1:0] rm;
   logic [7:0] rd, re;
   logic       ro;
   int         acc_n, res_n, bad4;
   int         acc_cyc[2];
   logic       acc_now;

   initial begin
      tab[0]  = '{2'd1, 8'h05, 8'hFB, 1'b0};
      tab[1]  = '{2'd2, 8'h80, OVF_RES, 1'b1};
      tab[2]  = '{2'd3, 8'h83, 8'hFD, 1'b0};
      tab[3]  = '{2'd3, 8'h80, 8'h00, 1'b0};
      tab[4]  = '{2'd3, 8'h05, 8'h05, 1'b0};
      tab[5]  = '{2'd0, 8'h5A, 8'h5A, 1'b0};
      tab[6]  = '{2'd0, 8'h80, 8'h80, 1'b0};
      tab[7]  = '{2'd2, 8'h81, 8'h7F, 1'b0};
      tab[8]  = '{2'd2, 8'h7F, 8'h7F, 1'b0};
      tab[9]  = '{2'd1, 8'h00, 8'h00, 1'b0};
      tab[10] = '{2'd1, 8'h80, OVF_RES, 1'b1};
      tab[11] = '{2'd1, 8'h01, 8'hFF, 1'b0};

      rst_n = 1'b0;
      v8 = 0; d8 = 0; m8 = 0; oready8 = 0;
      v4 = 0; d4 = 0; m4 = 0; oready4 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst8_outputs", {i8_ready, o8_valid, o8_ovf, o8_data}, 0);
      chk("rst4_outputs", {i4_ready, o4_valid, o4_ovf, o4_data}, 0);
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("rst_ready_before_edge", i8_ready, 0);
      @(posedge clk); #1;
      chk("rst_ready_after_edge", {i8_ready, i4_ready}, 2'b11);

      for (int i = 0; i < 12; i++)
         run8(tab[i].mode, tab[i].din, tab[i].exp_data, tab[i].exp_ovf, 0, $sformatf("vec%0d", i));

      run8(2'd2, 8'h80, OVF_RES, 1'b1, 10, "hold");

      repeat (40) begin
         rm = 2'($urandom_range(0, 3));
         rd = 8'($urandom);
         model8(rm, rd, re, ro);
         run8(rm, rd, re, ro, $urandom_range(0, 2), $sformatf("rand_m%0d_d%02h", rm, rd));
      end

      // WIDTH=4 back-to-back with in_valid and out_ready held high.
      v4 = 1'b1; m4 = 2'd0; d4 = 4'hA; oready4 = 1'b1;
      acc_n = 0; res_n = 0; bad4 = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
      for (int c = 0; c < 40 && res_n < 2; c++) begin
         @(negedge clk);
         if (acc_n == 1 && res_n == 0 && i4_ready) bad4++;
         if (o4_valid) begin
            chk(res_n == 0 ? "bb_pass_data" : "bb_neg_data", o4_data, res_n == 0 ? 4'hA : 4'hF);
            chk("bb_ovf", o4_ovf, 0);
            res_n++;
         end
         acc_now = v4 && i4_ready;
         if (acc_now) begin
            acc_cyc[acc_n] = c;
            acc_n++;
         end
         @(posedge clk); #1;
         if (acc_now && acc_n == 1) begin m4 = 2'd1; d4 = 4'h1; end
         if (acc_now && acc_n == 2) begin v4 = 1'b0; m4 = 2'd3; d4 = 4'h8; end
      end
      chk("bb_results", res_n, 2);
      chk("bb_accepts", acc_n, 2);
      chk("bb_ready_low", bad4, 0);
      chk("bb_gap", acc_cyc[1] - acc_cyc[0], 6);
      oready4 = 1'b0;

      // Reset asserted while bit 3 of a word is in flight.
      @(posedge clk); #1;
      m8 = 2'd1; d8 = 8'h37; v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {i8_ready, o8_valid, o8_ovf, o8_data}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run8(2'd1, 8'h01, 8'hFF, 1'b0, 0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
